// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI-flash target answering READ/JEDEC ID/READ STATUS from a byte-wide memory port.
// Pins are oversampled on clk; SCK phases must last at least 4 clk.
module spi_flash_responder #(
  parameter int ADDR_W = 22,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flash_cs,
  input  logic              flash_ck,
  input  logic              flash_si,
  output logic              flash_so,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic              active
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE} state_t;
  localparam logic [ADDR_W-1:0] addr_one = 1;
  state_t state, state_nx;
  logic [1:0] cs_s, si_s;
  logic [2:0] ck_s;
  logic cs, rise_ck, fall_ck, byte_end, issue, rd_d;
  logic [2:0] bit_cnt;
  logic [1:0] byte_cnt;
  logic [7:0] shift_in, shift_out, byte_in;
  logic [ADDR_W-1:0] addr_reg;

  // cs synchronizer resets to deselected so release from reset never looks like a select
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cs_s <= '1;
      ck_s <= '0;
      si_s <= '0;
    end else begin
      cs_s <= {cs_s[0], flash_cs};
      ck_s <= {ck_s[1:0], flash_ck};
      si_s <= {si_s[0], flash_si};
    end

  assign cs = cs_s[1];
  assign rise_ck = ck_s[1] & ~ck_s[2];
  assign fall_ck = ~ck_s[1] & ck_s[2];
  assign byte_in = {shift_in[6:0], si_s[1]};
  assign byte_end = rise_ck && bit_cnt == 3'd7;
  assign mem_addr = addr_reg;

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    if (cs) state_nx = IDLE;
    else
      case (state)
        IDLE: state_nx = CMD;
        CMD: if (byte_end) state_nx = byte_in == 8'h03 ? ADDR : byte_in == 8'h9F ? ID : byte_in == 8'h05 ? STAT : IGNORE;
        ADDR: if (issue) state_nx = DATA;
        default: state_nx = state;
      endcase
  end

  always_comb begin
    active = state != IDLE;
    issue = byte_end && (state == DATA || (state == ADDR && byte_cnt == 2'd2));
  end

  // rd_d marks the clk in which mem_data answers the previous mem_rd
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bit_cnt <= '0;
      byte_cnt <= '0;
      shift_in <= '0;
      shift_out <= '0;
      addr_reg <= '0;
      flash_so <= 1'b0;
      mem_rd <= 1'b0;
      rd_d <= 1'b0;
    end else if (cs) begin
      bit_cnt <= '0;
      byte_cnt <= '0;
      shift_in <= '0;
      shift_out <= '0;
      flash_so <= 1'b0;
      mem_rd <= 1'b0;
      rd_d <= 1'b0;
    end else begin
      mem_rd <= issue;
      rd_d <= mem_rd;
      if (rise_ck) begin
        shift_in <= byte_in;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (rise_ck && state == ADDR) addr_reg <= {addr_reg[ADDR_W-2:0], si_s[1]};
      else if (rd_d) addr_reg <= addr_reg + addr_one;
      if (fall_ck) begin
        flash_so <= shift_out[7];
        shift_out <= {shift_out[6:0], 1'b0};
      end else if (rd_d) shift_out <= mem_data;
      else if (byte_end && state == CMD) begin
        shift_out <= byte_in == 8'h9F ? JEDEC_ID[23:16] : 8'h00;
        byte_cnt <= 2'd0;
      end else if (byte_end && state == ADDR) byte_cnt <= byte_cnt + 2'd1;
      else if (byte_end && state == ID) begin
        shift_out <= byte_cnt == 2'd0 ? JEDEC_ID[15:8] : byte_cnt == 2'd1 ? JEDEC_ID[7:0] : 8'h00;
        byte_cnt <= byte_cnt == 2'd2 ? 2'd2 : byte_cnt + 2'd1;
      end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: vector-table and scoreboard bench driving two responders (ADDR_W 22 and 4) on shared pins.
`timescale 1ns/1ps
module tb_spi_flash_responder;
  typedef struct packed {
    logic [7:0]  op;
    logic [23:0] addr;
    logic [2:0]  n;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0, reset = 1'b0, cs = 1'b1, ck = 1'b0, si = 1'b0;
  logic so, rd, act, so4, rd4, act4;
  logic [21:0] addr;
  logic [3:0] addr4;
  logic [7:0] data = 8'h00, data4 = 8'h00;
  logic [7:0] mem [256];
  logic [21:0] qa [$];
  logic [3:0] qa4 [$];
  logic [7:0] qb [$];
  logic [7:0] qb4 [$];
  logic rd_p = 1'b0, rd4_p = 1'b0;
  int checks = 0, errors = 0;
  vec_t vecs [7];

  always #5 clk = ~clk;

  spi_flash_responder dut (
    .clk(clk), .reset(reset), .flash_cs(cs), .flash_ck(ck), .flash_si(si), .flash_so(so),
    .mem_addr(addr), .mem_rd(rd), .mem_data(data), .active(act)
  );

  spi_flash_responder #(.ADDR_W(4)) dut4 (
    .clk(clk), .reset(reset), .flash_cs(cs), .flash_ck(ck), .flash_si(si), .flash_so(so4),
    .mem_addr(addr4), .mem_rd(rd4), .mem_data(data4), .active(act4)
  );

  always @(posedge clk) begin
    if (rd) data <= mem[addr[7:0]];
    if (rd4) data4 <= mem[{4'h0, addr4}];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rd) begin
      check("mem_rd single clk", 32'(rd_p), 32'd0);
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_rd spurious: got addr %0h expected no read", addr);
      end else check("mem_addr", 32'(addr), 32'(qa.pop_front()));
    end
    if (rd4) begin
      check("mem_rd4 single clk", 32'(rd4_p), 32'd0);
      if (qa4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_rd4 spurious: got addr %0h expected no read", addr4);
      end else check("mem_addr4", 32'(addr4), 32'(qa4.pop_front()));
    end
    rd_p = rd;
    rd4_p = rd4;
  end

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx, output logic [7:0] rx4);
    rx = 8'h00;
    rx4 = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      si = tx[i];
      repeat (4) @(negedge clk);
      rx[i] = so;
      rx4[i] = so4;
      ck = 1'b1;
      repeat (4) @(negedge clk);
      ck = 1'b0;
    end
  endtask

  task automatic run(input vec_t v);
    logic [7:0] rx, rx4, e;
    cs = 1'b0;
    repeat (4) @(negedge clk);
    check("active selected", 32'({act, act4}), 32'h3);
    spi_bits(v.op, 8, rx, rx4);
    check("so during opcode", 32'({rx, rx4}), 32'h0);
    if (v.op == 8'h03) begin
      for (int k = 0; k <= int'(v.n); k++) begin
        qa.push_back(22'(v.addr + 24'(k)));
        qa4.push_back(4'(v.addr + 24'(k)));
      end
      for (int b = 2; b >= 0; b--) spi_bits(v.addr[8*b +: 8], 8, rx, rx4);
    end
    for (int k = 0; k < int'(v.n); k++) begin
      if (v.op == 8'h03) begin
        qb.push_back(mem[8'(v.addr + 24'(k))]);
        qb4.push_back(mem[{4'h0, 4'(v.addr + 24'(k))}]);
      end else begin
        e = v.exp[31 - 8*k -: 8];
        qb.push_back(e);
        qb4.push_back(e);
      end
      spi_bits(8'h00, 8, rx, rx4);
      check("so byte", 32'(rx), 32'(qb.pop_front()));
      check("so4 byte", 32'(rx4), 32'(qb4.pop_front()));
    end
    cs = 1'b1;
    repeat (8) @(negedge clk);
    check("active released", 32'({act, act4}), 32'h0);
    check("reads outstanding", 32'(qa.size() + qa4.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] rx, rx4;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[8'h10] = 8'hA5;
    mem[8'h11] = 8'h3C;
    vecs[0] = '{8'h03, 24'h000010, 3'd2, 32'h0};
    vecs[1] = '{8'h03, 24'h00000F, 3'd2, 32'h0};
    vecs[2] = '{8'h9F, 24'h0, 3'd4, 32'hEF401600};
    vecs[3] = '{8'hAB, 24'h0, 3'd2, 32'h0};
    vecs[4] = '{8'h05, 24'h0, 3'd3, 32'h0};
    vecs[5] = '{8'h03, 24'h3FFFFE, 3'd4, 32'h0};
    vecs[6] = '{8'h03, 24'h000100, 3'd3, 32'h0};
    for (int i = 0; i < 24; i++) begin
      cs = i[0];
      ck = i[1];
      si = i[2];
      @(negedge clk);
      check("outputs in reset", 32'({so, rd, act, so4, rd4, act4, addr, addr4}), 32'h0);
    end
    cs = 1'b1;
    ck = 1'b0;
    si = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("outputs after reset", 32'({so, rd, act, so4, rd4, act4}), 32'h0);
    for (int i = 0; i < 6; i++) run(vecs[i]);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(8'h03, 8, rx, rx4);
    spi_bits(8'h00, 8, rx, rx4);
    spi_bits(8'h01, 4, rx, rx4);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    check("active after abort", 32'({act, act4}), 32'h0);
    run(vecs[6]);
    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

Synthesizable SPI-flash target that answers the serial read protocol issued by the FPGATED bootstrap loader. It lets a design boot from a rompack held in on-chip block RAM or SDRAM instead of a physical flash. The block sits on the flash pins (flash_cs/flash_ck/flash_si/flash_so) on the target side, oversamples them on the system clock, and fetches payload bytes through a one-cycle-latency byte-wide memory read port. It supports READ (0x03), JEDEC ID (0x9F) and READ STATUS (0x05); other opcodes are ignored.

## Interface
Parameters:
- ADDR_W, 22, memory address width; the 24-bit flash address is truncated to the low ADDR_W bits.
- JEDEC_ID, 24'hEF4016, the three bytes returned by 0x9F, MSB first.

Ports:
- clk  input  1  system clock, 28.288 MHz nominal; single clock domain.
- reset  input  1  asynchronous, active-low reset.
- flash_cs  input  1  chip select, active low, asynchronous to clk.
- flash_ck  input  1  SPI clock, mode 0, asynchronous to clk.
- flash_si  input  1  serial data from initiator.
- flash_so  output  1  serial data to initiator.
- mem_addr  output  ADDR_W  byte address for memory read.
- mem_rd  output  1  one-clk read strobe.
- mem_data  input  8  read data, valid the clk after mem_rd.
- active  output  1  high while a transaction is selected (flash_cs low after sync).

## Operation
- Inputs cs/ck/si pass through 2-FF synchronizers; a third register on ck gives edge detect (rise_ck, fall_ck one-clk pulses).
- Synced cs high forces state IDLE, bit counter to 0, flash_so to 0, active to 0, regardless of the ck edge seen in that clk.
- On rise_ck: shift synced si into shift_in (MSB first) and increment bit counter (0-7, wraps).
- On fall_ck: flash_so <= shift_out[7]; shift_out <<= 1.
- States:
  - IDLE: cs low -> CMD, active=1.
  - CMD: after 8th rise_ck decode shift_in: 0x03 -> ADDR; 0x9F -> ID, shift_out=JEDEC_ID[23:16]; 0x05 -> STAT, shift_out=0x00; else -> IGNORE.
  - ADDR: collect 24 bits into addr_reg; on 24th rise_ck assert mem_rd with mem_addr=addr_reg[ADDR_W-1:0], go to DATA; next clk load shift_out=mem_data and increment addr_reg.
  - DATA: on each 8th rise_ck of a byte, mem_rd with current addr_reg; next clk load shift_out, increment addr_reg. Address wraps from 2^ADDR_W-1 to 0. Streaming is unbounded until cs rises.
  - ID: bytes JEDEC_ID[23:16], [15:8], [7:0], then 0x00 repeated.
  - STAT: 0x00 repeated (never busy, WEL=0).
  - IGNORE: flash_so held 0 until cs high.
- si bits during DATA/ID/STAT/IGNORE are ignored.

## Timing
- Reset values: flash_so=0, mem_rd=0, mem_addr=0, active=0, state IDLE, all shift registers and counters 0.
- Input-to-action latency: 3 clk from pin edge to rise_ck/fall_ck pulse.
- Byte load completes 2 clk after the detected 8th rising edge, before the following fall_ck, provided each SCK phase lasts >= 4 clk (SCK <= clk/8, 3.536 MHz at nominal clk). Faster SCK is unsupported; behaviour undefined.
- First data bit (bit 7 of byte at address A) appears on flash_so at the fall_ck following the last address bit, matching mode-0 read timing.
- mem_rd is exactly one clk per byte; never asserted in IDLE, CMD, STAT, ID, IGNORE.
- cs rising mid-byte or mid-address: transaction aborted, no mem_rd issued afterwards, next cs low restarts at CMD.
- cs falling and a ck edge in the same sync window: cs takes effect first; the edge counts as bit 0 of CMD.

## Test plan
- Reset: hold reset low with pins toggling -> flash_so=0, mem_rd=0, active=0 throughout.
- READ 0x03 addr 0x000010, SCK=clk/8, memory holds 0xA5,0x3C at 0x10,0x11 -> mem_rd at 0x10 then 0x11; flash_so bits 1010_0101 then 0011_1100.
- Wrap: ADDR_W=4, READ at 0x00000F streaming 2 bytes -> mem_addr 0xF then 0x0.
- JEDEC 0x9F -> flash_so bytes 0xEF,0x40,0x16,0x00; no mem_rd.
- Unknown opcode 0xAB followed by 16 clocks -> flash_so stays 0, no mem_rd; then 0x05 -> 0x00 returned.
- Abort: raise cs after 12 address bits, then new READ at 0x000100 -> first mem_rd at 0x100, correct data stream.
